// File: rtl/debug_run_controller_pkg.sv
// Shared types and default constants for the debug run controller.
// Holds state and stop-cause encodings, HLT encoding and width defaults.
package debug_run_controller_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_CHECK_HLT,
      S_STEP_WAIT,
      S_STEP_EXEC,
      S_SEND,
      S_WAIT_SEND,
      S_FINISH
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_HALT    = 2'd0,
      CAUSE_BP      = 2'd1,
      CAUSE_ABORT   = 2'd2,
      CAUSE_TIMEOUT = 2'd3
   } cause_t;

   localparam int          DEF_PROC_BITS        = 32;
   localparam int          DEF_PC_BITS          = 32;
   localparam int          DEF_CLK_COUNTER_BITS = 32;
   localparam logic [31:0] DEF_HLT_WORD         = 32'hFFFF_FFFF;
   localparam int          DEF_HLT_CONFIRM      = 3;
   localparam int          DEF_MAX_CYCLES       = 2**20;
   localparam int          HLT_CNT_BITS         = 8;

endpackage

// File: rtl/hlt_confirm_counter.sv
// Counts consecutive HLT words on enabled cycles; o_confirmed marks the cycle
// whose HLT completes a run of HLT_CONFIRM. Ports: clk, rst, i_clear, i_enable, i_hlt, o_confirmed.
module hlt_confirm_counter
   import debug_run_controller_pkg::*;
#(
   parameter int HLT_CONFIRM = DEF_HLT_CONFIRM
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_hlt,
   output logic o_confirmed
);

   logic [HLT_CNT_BITS-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (i_clear) begin
         cnt_q <= '0;
      end else if (i_enable) begin
         if (!i_hlt)
            cnt_q <= '0;
         else if (!(&cnt_q))
            cnt_q <= cnt_q + HLT_CNT_BITS'(1);
      end
   end

   // The current HLT counts toward the run, so the stop happens in that cycle.
   assign o_confirmed = i_enable && i_hlt &&
      (({1'b0, cnt_q} + (HLT_CNT_BITS+1)'(1)) >= (HLT_CNT_BITS+1)'(HLT_CONFIRM));

endmodule

// File: rtl/debug_run_controller.sv
// Run/step controller: gates the datapath enable, stops on HLT/breakpoint/abort,
// counts enabled cycles and requests dumps via o_send_start / i_send_done.
// Ports: i_start/i_mode launch, i_step, i_abort, i_instruction, i_pc, i_bp_valid,
// i_bp_addr, i_send_done; o_enable, o_send_start, o_clk_count, o_busy,
// o_stop_cause, o_done. Macro RUN_TIMEOUT_EN enables the MAX_CYCLES run limit.
module debug_run_controller
   import debug_run_controller_pkg::*;
#(
   parameter int PROC_BITS        = DEF_PROC_BITS,
   parameter int PC_BITS          = DEF_PC_BITS,
   parameter int CLK_COUNTER_BITS = DEF_CLK_COUNTER_BITS,
   parameter logic [PROC_BITS-1:0] HLT_WORD = PROC_BITS'(DEF_HLT_WORD),
   parameter int HLT_CONFIRM      = DEF_HLT_CONFIRM,
   parameter int MAX_CYCLES       = DEF_MAX_CYCLES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic                        i_mode,
   input  logic                        i_step,
   input  logic                        i_abort,
   input  logic [PROC_BITS-1:0]        i_instruction,
   input  logic [PC_BITS-1:0]          i_pc,
   input  logic                        i_bp_valid,
   input  logic [PC_BITS-1:0]          i_bp_addr,
   input  logic                        i_send_done,
   output logic                        o_enable,
   output logic                        o_send_start,
   output logic [CLK_COUNTER_BITS-1:0] o_clk_count,
   output logic                        o_busy,
   output logic [1:0]                  o_stop_cause,
   output logic                        o_done
);

`ifdef RUN_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [CLK_COUNTER_BITS-1:0] TIMEOUT_AT =
      CLK_COUNTER_BITS'(MAX_CYCLES - 1);

   state_t state_q, state_d;
   cause_t cause_q, cause_d;
   logic   cause_valid;
   logic   set_cause;
   logic   bp_mask;
   logic   start_go;
   logic   is_hlt;
   logic   bp_hit;
   logic   confirmed;
   logic   timeout_hit;

   assign start_go    = (state_q == S_IDLE) && i_start;
   assign is_hlt      = (i_instruction == HLT_WORD);
   // First RUN cycle of a session ignores the breakpoint so a resume can leave it.
   assign bp_hit      = i_bp_valid && (i_pc == i_bp_addr) && !bp_mask;
   assign timeout_hit = TIMEOUT_EN && (o_clk_count == TIMEOUT_AT);

   hlt_confirm_counter #(
      .HLT_CONFIRM(HLT_CONFIRM)
   ) u_hlt (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (start_go),
      .i_enable   (o_enable),
      .i_hlt      (is_hlt),
      .o_confirmed(confirmed)
   );

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      set_cause = 1'b0;
      unique case (state_q)
         S_IDLE:
            if (i_start)
               state_d = i_mode ? S_STEP_WAIT : S_RUN;
         S_RUN, S_CHECK_HLT: begin
            if (i_abort) begin
               state_d = S_SEND; set_cause = 1'b1; cause_d = CAUSE_ABORT;
            end else if (timeout_hit) begin
               state_d = S_SEND; set_cause = 1'b1; cause_d = CAUSE_TIMEOUT;
            end else if (confirmed) begin
               state_d = S_SEND; set_cause = 1'b1; cause_d = CAUSE_HALT;
            end else if (state_q == S_RUN && bp_hit) begin
               state_d = S_SEND; set_cause = 1'b1; cause_d = CAUSE_BP;
            end else if (state_q == S_RUN && is_hlt) begin
               state_d = S_CHECK_HLT;
            end else if (state_q == S_CHECK_HLT && !is_hlt) begin
               state_d = S_RUN;
            end
         end
         S_STEP_WAIT: begin
            if (i_abort) begin
               state_d = S_SEND; set_cause = 1'b1; cause_d = CAUSE_ABORT;
            end else if (i_step) begin
               state_d = S_STEP_EXEC;
            end
         end
         S_STEP_EXEC: begin
            state_d = S_SEND;
            if (i_abort) begin
               set_cause = 1'b1; cause_d = CAUSE_ABORT;
            end
         end
         S_SEND:
            state_d = S_WAIT_SEND;
         S_WAIT_SEND:
            if (i_send_done)
               state_d = cause_valid ? S_FINISH : S_STEP_WAIT;
         S_FINISH:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_enable     = 1'b0;
      o_send_start = 1'b0;
      o_done       = 1'b0;
      o_busy       = (state_q != S_IDLE);
      unique case (state_q)
         S_RUN, S_CHECK_HLT, S_STEP_EXEC: o_enable     = 1'b1;
         S_SEND:                          o_send_start = 1'b1;
         S_FINISH:                        o_done       = 1'b1;
         default: ;
      endcase
   end

   assign o_stop_cause = cause_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cause_q     <= CAUSE_HALT;
         cause_valid <= 1'b0;
         bp_mask     <= 1'b0;
         o_clk_count <= '0;
      end else begin
         state_q <= state_d;
         bp_mask <= start_go && !i_mode;
         if (start_go) begin
            o_clk_count <= '0;
            cause_q     <= CAUSE_HALT;
            cause_valid <= 1'b0;
         end else begin
            if (o_enable && !(&o_clk_count))
               o_clk_count <= o_clk_count + CLK_COUNTER_BITS'(1);
            if (set_cause) begin
               cause_q     <= cause_d;
               cause_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_debug_run_controller.sv
// Bench for debug_run_controller: session-level model plus directed sessions.
// Instruction and PC are fed from a program indexed by the enabled-cycle count.
module tb_debug_run_controller;

   localparam int          CW   = 6;
   localparam int          CONF = 3;
   localparam int          MAXC = 16;
   localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef RUN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start, i_mode, i_step, i_abort;
   logic [31:0]   i_instruction;
   logic [31:0]   i_pc;
   logic          i_bp_valid;
   logic [31:0]   i_bp_addr;
   logic          i_send_done;
   logic          o_enable, o_send_start, o_busy, o_done;
   logic [CW-1:0] o_clk_count;
   logic [1:0]    o_stop_cause;

   logic [31:0]   prog [64];
   logic [31:0]   pc_base;
   int            checks = 0;
   int            errors = 0;
   int            n_en = 0;
   int            n_send = 0;
   int            e0, s0;

   // model state
   logic          m_active, m_mode, m_go, m_dump, m_wait, m_fin;
   logic          m_first, m_stopped;
   int            m_streak;
   logic [CW-1:0] m_cnt;
   logic [1:0]    m_cause;

   debug_run_controller #(
      .PROC_BITS       (32),
      .PC_BITS         (32),
      .CLK_COUNTER_BITS(CW),
      .HLT_CONFIRM     (CONF),
      .MAX_CYCLES      (MAXC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_mode       (i_mode),
      .i_step       (i_step),
      .i_abort      (i_abort),
      .i_instruction(i_instruction),
      .i_pc         (i_pc),
      .i_bp_valid   (i_bp_valid),
      .i_bp_addr    (i_bp_addr),
      .i_send_done  (i_send_done),
      .o_enable     (o_enable),
      .o_send_start (o_send_start),
      .o_clk_count  (o_clk_count),
      .o_busy       (o_busy),
      .o_stop_cause (o_stop_cause),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   assign i_instruction = prog[m_cnt];
   assign i_pc          = pc_base + 32'({m_cnt, 2'b00});

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Session model: a session is active from start until its done pulse;
   // m_streak is the number of consecutive HLT words seen while enabled.
   always @(posedge clk or posedge rst) begin : model
      logic hlt, bp;
      int   streak, stop;
      if (rst) begin
         m_active <= 0; m_mode <= 0; m_go <= 0; m_dump <= 0;
         m_wait <= 0; m_fin <= 0; m_first <= 0; m_stopped <= 0;
         m_streak <= 0; m_cnt <= '0; m_cause <= 2'd0;
      end else begin
         hlt    = (i_instruction == HLT);
         bp     = i_bp_valid && (i_pc == i_bp_addr);
         stop   = -1;
         streak = hlt ? m_streak + 1 : 0;
         if (!m_active) begin
            if (i_start) begin
               m_active <= 1; m_mode <= i_mode; m_go <= !i_mode;
               m_first <= !i_mode; m_cnt <= '0; m_streak <= 0;
               m_stopped <= 0; m_cause <= 2'd0;
            end
         end else if (m_go) begin
            m_cnt    <= (&m_cnt) ? m_cnt : m_cnt + 1'b1;
            m_streak <= streak;
            m_first  <= 0;
            if (i_abort) stop = 2;
            else if (!m_mode) begin
               if (TO_EN && m_cnt == CW'(MAXC - 1)) stop = 3;
               else if (streak >= CONF) stop = 0;
               else if (!m_first && m_streak == 0 && bp) stop = 1;
            end
            if (stop >= 0 || m_mode) begin
               m_go <= 0; m_dump <= 1;
            end
            if (stop >= 0) begin
               m_stopped <= 1; m_cause <= 2'(stop);
            end
         end else if (m_dump) begin
            m_dump <= 0; m_wait <= 1;
         end else if (m_wait) begin
            if (i_send_done) begin
               m_wait <= 0; m_fin <= m_stopped;
            end
         end else if (m_fin) begin
            m_fin <= 0; m_active <= 0;
         end else if (i_abort) begin
            m_dump <= 1; m_stopped <= 1; m_cause <= 2'd2;
         end else if (i_step) begin
            m_go <= 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("cmp_enable", 64'(o_enable), 64'(m_go));
         check("cmp_send_start", 64'(o_send_start), 64'(m_dump));
         check("cmp_done", 64'(o_done), 64'(m_fin));
         check("cmp_busy", 64'(o_busy), 64'(m_active));
         check("cmp_count", 64'(o_clk_count), 64'(m_cnt));
         if (m_fin)
            check("cmp_cause", 64'(o_stop_cause), 64'(m_cause));
      end
   end

   always @(posedge clk) begin
      if (!rst && o_enable) n_en <= n_en + 1;
      if (!rst && o_send_start) n_send <= n_send + 1;
   end

   task automatic start_session(input logic mode);
      i_start = 1; i_mode = mode;
      @(negedge clk);
      i_start = 0; i_mode = 0;
   endtask

   task automatic wait_send(input string name, input int lim);
      int i = 0;
      while (!o_send_start && i < lim) begin
         @(negedge clk); i++;
      end
      check({name, "_send_seen"}, 64'(o_send_start), 64'(1));
   endtask

   task automatic wait_done(input string name, input int lim);
      int i = 0;
      while (!o_done && i < lim) begin
         @(negedge clk); i++;
      end
      check({name, "_done_seen"}, 64'(o_done), 64'(1));
   endtask

   task automatic serve_dump();
      @(negedge clk);
      i_send_done = 1;
      @(negedge clk);
      i_send_done = 0;
   endtask

   task automatic do_abort(input string name);
      i_abort = 1;
      @(negedge clk);
      i_abort = 0;
      wait_send(name, 5);
      serve_dump();
      wait_done(name, 5);
      check({name, "_cause"}, 64'(o_stop_cause), 64'(2));
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; i_start = 0; i_mode = 0; i_step = 0; i_abort = 0;
      i_bp_valid = 0; i_bp_addr = 0; i_send_done = 0; pc_base = 0;
      for (int k = 0; k < 64; k++) prog[k] = NOP;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst_enable", 64'(o_enable), 64'(0));
      check("rst_send", 64'(o_send_start), 64'(0));
      check("rst_busy", 64'(o_busy), 64'(0));
      check("rst_done", 64'(o_done), 64'(0));
      check("rst_count", 64'(o_clk_count), 64'(0));
      check("rst_cause", 64'(o_stop_cause), 64'(0));

      // 5 NOPs then HLT forever: 8 enabled cycles
      for (int k = 0; k < 64; k++) prog[k] = (k < 5) ? NOP : HLT;
      e0 = n_en; s0 = n_send;
      start_session(1'b0);
      wait_send("t1", 40);
      check("t1_count", 64'(o_clk_count), 64'(8));
      serve_dump();
      wait_done("t1", 5);
      check("t1_cause", 64'(o_stop_cause), 64'(0));
      check("t1_enables", 64'(n_en - e0), 64'(8));
      check("t1_sends", 64'(n_send - s0), 64'(1));
      @(negedge clk);
      check("t1_idle", 64'(o_busy), 64'(0));

      // broken HLT pairs do not stop; confirmed run at index 8..10 does
      for (int k = 0; k < 64; k++) prog[k] = HLT;
      prog[2] = NOP; prog[3] = NOP; prog[6] = NOP; prog[7] = NOP;
      s0 = n_send;
      start_session(1'b0);
      wait_send("t2", 40);
      check("t2_count", 64'(o_clk_count), 64'(11));
      serve_dump();
      wait_done("t2", 5);
      check("t2_cause", 64'(o_stop_cause), 64'(0));
      check("t2_sends", 64'(n_send - s0), 64'(1));
      @(negedge clk);

      // breakpoint at 0x40 with PC stepping by 4
      for (int k = 0; k < 64; k++) prog[k] = NOP;
      i_bp_valid = 1; i_bp_addr = 32'h40; pc_base = 0;
      start_session(1'b0);
      wait_send("t3", 40);
      check("t3_count", 64'(o_clk_count), 64'(17));
      serve_dump();
      wait_done("t3", 5);
      check("t3_cause", 64'(o_stop_cause), 64'(1));
      @(negedge clk);
      pc_base = 32'h40; s0 = n_send;
      start_session(1'b0);
      check("t3_resume_pc", 64'(i_pc), 64'(32'h40));
      repeat (6) @(negedge clk);
      check("t3_no_retrigger", 64'(n_send - s0), 64'(0));
      check("t3_running", 64'(o_enable), 64'(1));
      do_abort("t3b");
      i_bp_valid = 0; pc_base = 0;

      // step mode: 3 steps, a stray step while waiting on the dump
      e0 = n_en; s0 = n_send;
      start_session(1'b1);
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         i_step = 1;
         @(negedge clk);
         i_step = 0;
         wait_send("t4", 5);
         @(negedge clk);
         i_step = 1;
         @(negedge clk);
         i_step = 0; i_send_done = 1;
         @(negedge clk);
         i_send_done = 0;
         check("t4_busy", 64'(o_busy), 64'(1));
      end
      check("t4_count", 64'(o_clk_count), 64'(3));
      check("t4_enables", 64'(n_en - e0), 64'(3));
      check("t4_sends", 64'(n_send - s0), 64'(3));
      do_abort("t4");

      // abort together with HLT in the first RUN cycle
      for (int k = 0; k < 64; k++) prog[k] = HLT;
      start_session(1'b0);
      i_abort = 1;
      @(negedge clk);
      i_abort = 0;
      wait_send("t5", 5);
      check("t5_count", 64'(o_clk_count), 64'(1));
      serve_dump();
      wait_done("t5", 5);
      check("t5_cause", 64'(o_stop_cause), 64'(2));
      @(negedge clk);

      // asynchronous reset while waiting on a dump
      start_session(1'b0);
      i_abort = 1;
      @(negedge clk);
      i_abort = 0;
      wait_send("t5r", 5);
      @(negedge clk);
      #2 rst = 1;
      #1;
      check("t5r_enable", 64'(o_enable), 64'(0));
      check("t5r_send", 64'(o_send_start), 64'(0));
      check("t5r_busy", 64'(o_busy), 64'(0));
      check("t5r_done", 64'(o_done), 64'(0));
      check("t5r_count", 64'(o_clk_count), 64'(0));
      check("t5r_cause", 64'(o_stop_cause), 64'(0));
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      // long run of NOPs
      for (int k = 0; k < 64; k++) prog[k] = NOP;
      s0 = n_send;
      start_session(1'b0);
`ifdef RUN_TIMEOUT_EN
      wait_send("t6", 40);
      check("t6_count", 64'(o_clk_count), 64'(16));
      serve_dump();
      wait_done("t6", 5);
      check("t6_cause", 64'(o_stop_cause), 64'(3));
      @(negedge clk);
`else
      repeat (1000) @(negedge clk);
      check("t6_no_stop", 64'(n_send - s0), 64'(0));
      check("t6_running", 64'(o_enable), 64'(1));
      check("t6_saturated", 64'(o_clk_count), 64'(63));
      do_abort("t6");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
